// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin arbiter that shares the write port of one dual-clock FIFO among
// NREQ producers living in the FIFO's write clock domain. A winner keeps the
// port for a burst of up to BURST words. Every burst is followed by one IDLE
// cycle.
//
// Ports
//   clk              write-domain clock
//   wrst_n           synchronous active-low reset
//   req[NREQ]        per-requester "word available" level
//   wdata            packed requester data, slice i = wdata[i*DATESIZE +: DATESIZE]
//   ack[NREQ]        one-hot: requester's current word is written this cycle
//   fifo_wdata       to FIFO wdata (zero while idle)
//   fifo_winc        to FIFO winc
//   fifo_wfull       from FIFO wfull (stalls a burst)
//   fifo_almost_full from FIFO almost_full (blocks new grants only)
//   grant_id         index of the current or last granted requester
//   busy             1 while a burst is in progress (XFER state)
//
// Handshake: a word moves when fifo_winc is 1 at a rising clk. ack[i] mirrors
// fifo_winc for the granted requester, and that requester presents its next
// word after the same edge. req[i] is a level, not a pulse.
module fifo_wr_arbiter #(
   parameter int DATESIZE = 8,
   parameter int NREQ     = 4,
   parameter int BURST    = 4
) (
   input  logic                     clk,
   input  logic                     wrst_n,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ*DATESIZE-1:0] wdata,
   output logic [NREQ-1:0]          ack,
   output logic [DATESIZE-1:0]      fifo_wdata,
   output logic                     fifo_winc,
   input  logic                     fifo_wfull,
   input  logic                     fifo_almost_full,
   output logic [$clog2(NREQ)-1:0]  grant_id,
   output logic                     busy
);

   localparam int         IDW       = $clog2(NREQ);
   localparam logic [7:0] LAST_BEAT = 8'(BURST - 1);

   typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

   state_t         state;
   state_t         state_nxt;
   logic [IDW-1:0] last;
   logic [IDW-1:0] sel;
   logic [IDW-1:0] idx;
   logic           sel_valid;
   logic [7:0]     beats;
   logic           req_cur;
   logic           burst_done;
   logic           xfer_exit;

   // Rotating priority: scan last+1, last+2, ... wrapping modulo NREQ, so the
   // requester served most recently is considered last.
   always_comb begin
      sel       = '0;
      sel_valid = 1'b0;
      idx       = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = IDW'((int'(last) + k) % NREQ);
         if (!sel_valid && req[idx]) begin
            sel       = idx;
            sel_valid = 1'b1;
         end
      end
   end

   assign req_cur    = req[grant_id];
   assign burst_done = fifo_winc && (beats == LAST_BEAT);
   // A dropped req ends the burst with no write in that cycle.
   assign xfer_exit  = !req_cur || burst_done;

   // State register
   always_ff @(posedge clk) begin
      if (!wrst_n) state <= IDLE;
      else         state <= state_nxt;
   end

   // Next-state logic. almost_full only gates new grants; once a burst has
   // started, wfull alone protects the FIFO.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (sel_valid && !fifo_almost_full) state_nxt = XFER;
         XFER: if (xfer_exit)                      state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic. wrst_n is folded into winc so a reset asserted mid-burst
   // suppresses the write in that same cycle.
   always_comb begin
      busy       = (state == XFER);
      fifo_winc  = (state == XFER) && req_cur && !fifo_wfull && wrst_n;
      ack        = '0;
      ack[grant_id] = fifo_winc;
      fifo_wdata = '0;
      if (state == XFER) begin
         for (int i = 0; i < NREQ; i++) begin
            if (grant_id == IDW'(i)) fifo_wdata = wdata[i*DATESIZE +: DATESIZE];
         end
      end
   end

   // Grant bookkeeping and beat counter
   always_ff @(posedge clk) begin
      if (!wrst_n) begin
         grant_id <= '0;
         last     <= IDW'(NREQ - 1);
         beats    <= '0;
      end else if (state == IDLE) begin
         if (state_nxt == XFER) begin
            grant_id <= sel;
            beats    <= '0;
         end
      end else begin
         if (xfer_exit) begin
            last  <= grant_id;
            beats <= '0;
         end else if (fifo_winc) begin
            beats <= beats + 8'd1;
         end
      end
   end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the write port of one dual-clock FIFO among NREQ producers in the FIFO's write clock domain (e.g. audio/DMA sources feeding a cross-domain FIFO).
- Grants one requester at a time for a burst of up to BURST words.
- Throttles on the FIFO's full/almost-full flags.
- Drives the FIFO's wdata/winc directly.

Parameters:
- DATESIZE, 8, word width; matches the FIFO data width.
- NREQ, 4, number of requesters, 2..8.
- BURST, 4, max words per grant, 1..255.

Ports:
- clk  in  1  write-domain clock.
- wrst_n  in  1  reset.
- req  in  NREQ  per-requester "word available" level; req[i] with wdata slice i.
- wdata  in  NREQ*DATESIZE  packed requester data; slice i = wdata[i*DATESIZE +: DATESIZE].
- ack  out  NREQ  one-hot pulse: requester's current word written this cycle; requester advances its data on the next edge.
- fifo_wdata  out  DATESIZE  to FIFO wdata.
- fifo_winc  out  1  to FIFO winc.
- fifo_wfull  in  1  from FIFO wfull.
- fifo_almost_full  in  1  from FIFO almost_full.
- grant_id  out  $clog2(NREQ)  index of current/last granted requester.
- busy  out  1  1 while in XFER.

Interface notes:
- One clock.
- Reset is synchronous and active-low.

Behaviour:
State and reset:
- States IDLE, XFER. Registers: state, grant_id, last (last served index), beats (8-bit count).
- Sync reset (wrst_n=0 at posedge): state=IDLE, grant_id=0, last=NREQ-1, beats=0.
- busy=0, fifo_winc=0, ack=0, fifo_wdata=0 after reset.
- Requester 0 wins the first arbitration.

IDLE:
- If any req and fifo_almost_full=0, select the first set req scanning last+1, last+2, … mod NREQ.
- Next edge: grant_id=sel, beats=0, state=XFER.
- No grant while fifo_almost_full=1; a pending req waits in IDLE.
- No write ever occurs in IDLE.

XFER (combinational outputs):
- fifo_wdata = wdata slice grant_id; zero in IDLE.
- fifo_winc = req[grant_id] & ~fifo_wfull & wrst_n.
- ack[grant_id] = fifo_winc; all other ack bits 0.

XFER (registered):
- On fifo_winc, beats += 1.
- Exit to IDLE (last=grant_id, beats=0) at the edge when either:
  - req[grant_id]=0 (no write this cycle), or
  - fifo_winc=1 and beats==BURST-1 (burst complete).
- fifo_wfull=1 stalls in XFER with no write and no ack; beats holds; the burst resumes when full clears.
- fifo_almost_full is ignored mid-burst. wfull alone guarantees no overflow because the FIFO gates writes when full.

Timing:
- Grant latency: 1 cycle from req (IDLE) to first write.
- Mandatory 1-cycle IDLE gap between bursts, including when the same requester is re-granted.
- Max throughput: BURST words per BURST+1 cycles.

Boundary cases:
- Only one requester active: it is re-granted after each IDLE gap; no starvation logic needed.
- Requester drops req mid-burst: burst ends, and rotation moves past it.
- wrst_n low mid-burst: fifo_winc/ack are forced 0 in that same cycle; IDLE from the next edge; the partial burst is abandoned with no partial-word hazard.
- BURST=1: every write returns to IDLE.

Arithmetic:
- beats is 8 bits, compared against BURST-1, so no wrap for BURST≤255.
- Rotation index wraps modulo NREQ; NREQ need not be a power of 2.

Test Plan:
- Reset then req=4'b0001, FIFO never full -> first fifo_winc 1 cycle after IDLE grant. Writes words D0..D3 with ack[0] each cycle. busy drops after 4th write, 1 idle cycle, then re-grant of 0.
- req=4'b1111 held, distinct data per requester, BURST=4 -> write order 0×4, 1×4, 2×4, 3×4, 0×4. Exactly one idle cycle between bursts; grant_id follows 0,1,2,3,0.
- Requester 2 alone, fifo_wfull forced 1 for 3 cycles after its 2nd write -> no winc/ack for those 3 cycles, beats held at 2. Words 3 and 4 then written; total 4 writes, none lost or duplicated.
- fifo_almost_full=1 with req=4'b0010 in IDLE -> no grant, busy=0, no winc. Deassert -> grant_id=1 next edge, write the following cycle. Almost_full asserted mid-burst -> burst continues.
- req[1] dropped after 2 words of a 4-word burst with req[3] pending -> XFER exits, IDLE, grant_id=3. Requester 1 gets 2 acks total.
- wrst_n pulsed low during XFER beat 1 -> fifo_winc=0 in the reset cycle. After release: state IDLE, grant_id=0, last=NREQ-1, and the next arbitration starts from requester 0.
